// File: rtl/cdc_sched_pkg.sv
// Shared types and helpers for the CDC pulse scheduler and its arbiter.
package cdc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter
  import cdc_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx
);

  logic          w_hi_found;
  logic          w_lo_found;
  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;

  // Lowest request above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (req[j] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IW'(j);
      end
      if (req[j] && !w_hi_found && (IW'(j) > last_grant)) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IW'(j);
      end
    end
    grant_valid = w_lo_found;
    grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/cdc_pulse_sched.sv
// Serialises per-requester event counts onto one spaced pulse line with a
// quasi-static id bus, for a toggle-based pulse synchroniser.
module cdc_pulse_sched
  import cdc_sched_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned CNT_W = 4,
  parameter  int unsigned GAP   = 8,
  localparam int unsigned IW    = idx_w(NREQ)
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            overflow_clr,
  output logic            out_pulse,
  output logic [IW-1:0]   out_id,
  output logic            busy,
  output logic [NREQ-1:0] overflow
);

  localparam int unsigned    GW       = idx_w(GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 2);

  logic [CNT_W-1:0] r_cnt     [NREQ];
  logic [CNT_W-1:0] w_cnt_nxt [NREQ];
  logic [NREQ-1:0]  w_cand;
  logic [NREQ-1:0]  w_dec;
  logic [NREQ-1:0]  w_ovf_set;
  logic [NREQ-1:0]  r_ovf;
  logic             w_any_next;

  state_t           r_state;
  state_t           w_next;
  logic [GW-1:0]    r_gap;
  logic [IW-1:0]    r_last_grant;
  logic [IW-1:0]    r_out_id;
  logic             r_out_pulse;
  logic             r_busy;
  logic             w_take;
  logic             w_grant_valid;
  logic [IW-1:0]    w_grant_idx;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req        (w_cand),
    .last_grant (r_last_grant),
    .grant_valid(w_grant_valid),
    .grant_idx  (w_grant_idx)
  );

  // The granted count is decremented while its pulse is on the wire; a
  // simultaneous strobe cancels the decrement instead of being dropped.
  always_comb begin
    w_any_next = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand[i]    = (r_cnt[i] != '0);
      w_dec[i]     = (r_state == ISSUE) && (r_out_id == IW'(i));
      w_ovf_set[i] = 1'b0;
      w_cnt_nxt[i] = r_cnt[i];
      if (req[i] && !w_dec[i]) begin
        if (r_cnt[i] == CNT_MAX) w_ovf_set[i] = 1'b1;
        else                     w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end else if (!req[i] && w_dec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      end
      if (w_cnt_nxt[i] != '0) w_any_next = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_take = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (r_gap == '0) begin
          if (w_grant_valid) begin
            w_take = 1'b1;
            w_next = ISSUE;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) r_cnt[i] <= '0;
      r_ovf        <= '0;
      r_state      <= IDLE;
      r_gap        <= '0;
      r_last_grant <= IW'(NREQ - 1);
      r_out_id     <= '0;
      r_out_pulse  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_ovf   <= w_ovf_set | (r_ovf & ~{NREQ{overflow_clr}});
      r_state <= w_next;
      if (r_state == ISSUE)                  r_gap <= GAP_LOAD;
      else if (r_state == WAIT && r_gap != '0) r_gap <= r_gap - 1'b1;
      // Pulse and id are registered from the grant so they appear together in ISSUE.
      r_out_pulse <= w_take;
      if (w_take) begin
        r_out_id     <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
      r_busy <= (w_next != IDLE) || w_any_next;
    end
  end

  assign out_pulse = r_out_pulse;
  assign out_id    = r_out_id;
  assign busy      = r_busy;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_cdc_pulse_sched.sv
// Self-checking bench: timestamp-based event model plus directed literal checks.
module tb_cdc_pulse_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP   = 8;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic            overflow_clr;
  logic            out_pulse;
  logic [1:0]      out_id;
  logic            busy;
  logic [NREQ-1:0] overflow;

  always #5 clk_sys = ~clk_sys;

  cdc_pulse_sched #(
    .NREQ (NREQ),
    .CNT_W(CNT_W),
    .GAP  (GAP)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req         (req),
    .overflow_clr(overflow_clr),
    .out_pulse   (out_pulse),
    .out_id      (out_id),
    .busy        (busy),
    .overflow    (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: pending event counts, round-robin pointer and the time of the last
  // pulse; a new pick is allowed when idle or GAP-1 cycles after a pulse.
  int              m_cnt [NREQ];
  bit [NREQ-1:0]   m_ovf;
  int              m_lg;
  bit              m_pulse;
  int              m_id;
  bit              m_busy;
  bit              m_idle;
  int              m_last_p;
  int              cyc;
  int              m_events;
  int              dut_pulses;

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    m_ovf      = '0;
    m_lg       = NREQ - 1;
    m_pulse    = 0;
    m_id       = 0;
    m_busy     = 0;
    m_idle     = 1;
    m_last_p   = -1000;
    m_events   = 0;
    dut_pulses = 0;
  endtask

  always @(negedge clk_sys) begin : model
    bit grant, nidle, anyc, dec, setb;
    int g, j;
    if (reset) model_reset();
    chk("pulse", int'(out_pulse), int'(m_pulse));
    chk("id", int'(out_id), m_id);
    chk("busy", int'(busy), int'(m_busy));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (!reset) begin
      if (out_pulse) dut_pulses++;
      grant = 0;
      g     = 0;
      nidle = m_idle;
      if (m_idle || cyc == m_last_p + int'(GAP) - 1) begin
        for (int k = 1; k <= NREQ; k++) begin
          j = (m_lg + k) % NREQ;
          if (!grant && m_cnt[j] != 0) begin
            grant = 1;
            g     = j;
          end
        end
        nidle = !grant;
        if (grant) begin
          m_lg     = g;
          m_last_p = cyc + 1;
        end
      end
      anyc = 0;
      for (int i = 0; i < NREQ; i++) begin
        dec  = m_pulse && (m_id == i);
        setb = 0;
        if (req[i]) begin
          if (dec) m_events++;
          else if (m_cnt[i] == CMAX) setb = 1;
          else begin
            m_cnt[i]++;
            m_events++;
          end
        end else if (dec) begin
          m_cnt[i]--;
        end
        m_ovf[i] = setb | (m_ovf[i] & !overflow_clr);
        if (m_cnt[i] != 0) anyc = 1;
      end
      m_pulse = grant;
      if (grant) m_id = g;
      m_idle = nidle;
      m_busy = !nidle || anyc;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_pulse(output int dt, output int id);
    dt = 0;
    while (!out_pulse && dt < 200) begin
      tick();
      dt++;
    end
    id = int'(out_id);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk(nm, int'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int dt, id, n;
    bit heavy;
    logic [NREQ-1:0] rv;
    reset = 1'b1;
    req = '0;
    overflow_clr = 1'b0;
    heavy = 0;
    tick();
    tick();
    chk("rst_pulse", int'(out_pulse), 0);
    chk("rst_id", int'(out_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    tick();

    // Single event on requester 2.
    req = 4'b0100;
    tick();
    req = '0;
    wait_pulse(dt, id);
    chk("single_latency", dt + 1, 2);
    chk("single_id", id, 2);
    tick();
    chk("single_width", int'(out_pulse), 0);
    chk("single_id_hold", int'(out_id), 2);
    n = 1;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("single_busy_fall", n, GAP);

    // Fairness from a fresh reset.
    do_reset();
    req = 4'b1111;
    tick();
    req = '0;
    wait_pulse(dt, id);
    chk("fair_id0", id, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      wait_pulse(dt, id);
      chk("fair_spacing", dt + 1, GAP);
      chk("fair_id", id, k);
    end
    wait_idle("fair_idle");

    // Burst with saturation on requester 1.
    n = 0;
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 19) req = '0;
      if (out_pulse && out_id == 2'd1) n++;
    end
    while (busy && n < 100) begin
      tick();
      if (out_pulse && out_id == 2'd1) n++;
    end
    chk("burst_pulses", n, 18);
    chk("burst_ovf", int'(overflow), 2);

    // Overflow clear alone, then clear racing a saturating strobe.
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_alone", int'(overflow), 0);
    req = 4'b1000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 20) req = '0;
      overflow_clr = (i >= 18);
      if (i == 19) chk("clr_before_race", int'(overflow), 0);
      if (i == 20) chk("set_wins_race", int'(overflow), 8);
    end
    tick();
    overflow_clr = 1'b0;
    chk("clr_after_race", int'(overflow), 0);
    wait_idle("race_idle");

    // Reset in WAIT with several requesters pending.
    do_reset();
    req = 4'b1011;
    tick();
    req = 4'b0011;
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    repeat (9) tick();
    chk("midrst_pre_busy", int'(busy), 1);
    chk("midrst_pre_id", int'(out_id), 1);
    reset = 1'b1;
    #1;
    chk("midrst_pulse", int'(out_pulse), 0);
    chk("midrst_id", int'(out_id), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(overflow), 0);
    tick();
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 3 * GAP; i++) begin
      tick();
      if (out_pulse) n++;
    end
    chk("midrst_no_pulse", n, 0);
    req = 4'b0001;
    tick();
    req = '0;
    wait_pulse(dt, id);
    chk("midrst_new_latency", dt + 1, 2);
    chk("midrst_new_id", id, 0);
    wait_idle("midrst_idle");

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) heavy = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NREQ; i++)
        rv[i] = heavy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      req          = rv;
      overflow_clr = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    req = '0;
    overflow_clr = 1'b0;
    reset = 1'b0;
    tick();
    wait_idle("rand_idle");
    tick();
    chk("rand_events_vs_pulses", dut_pulses, m_events);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
